line_writeback: RTL

Write-back stage of the Game-of-Life datapath. Accepts next-state rows from `parallel_next_state`, buffers them in a small row FIFO, and writes each one to the write port of the frame BRAM at its row address. It is the writer counterpart of the line-buffer read path. Write commits are gated by a grant from the BRAM port arbiter. The block also signals frame completion to the line iterator.

---
 rtl/line_writeback_pkg.sv | 12 +
 rtl/line_writeback_row_fifo.sv | 50 +++++
 rtl/line_writeback.sv | 114 +++++++++++
 3 files changed

// File: rtl/line_writeback_pkg.sv
// Shared constants and FSM state type for the Game-of-Life write-back stage.
package lwb_pkg;
  localparam int unsigned COLS   = 1280;
  localparam int unsigned ROWS   = 720;
  localparam int unsigned ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } lwb_state_e;
endpackage

// File: rtl/line_writeback_row_fifo.sv
// Small row FIFO: DEPTH entries of W bits, registered count, head always presented.
module row_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/line_writeback.sv
// Write-back stage: filters next-state rows, queues them and writes them to the
// frame BRAM under arbiter grant; pulses frame_done after the last row commits.
// Optional row-sequence checker enabled by defining LWB_SEQ_CHECK_EN.
module line_writeback #(
  parameter int unsigned COLS   = lwb_pkg::COLS,
  parameter int unsigned ROWS   = lwb_pkg::ROWS,
  parameter int unsigned ADDR_W = lwb_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_row,
  input  logic                     in_flag,
  input  logic [COLS-1:0]          in_data,
  output logic                     wr_en,
  input  logic                     wr_grant,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [COLS-1:0]          wr_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     frame_done
`ifdef LWB_SEQ_CHECK_EN
  ,
  output logic                     seq_err
`endif
);
  import lwb_pkg::*;

  localparam int unsigned        CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  LAST_ROW = ADDR_W'(ROWS - 1);

  logic                   init_q;
  logic                   accept, push, commit;
  logic [CNT_W-1:0]       count;
  logic [ADDR_W+COLS-1:0] head;
  lwb_state_e             state_q;
  logic                   frame_done_q;

  // Ready is held low through reset and rises on the first edge after release,
  // so it is qualified by a one-shot flag rather than the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  assign in_ready = init_q && (count != FULL_CNT);
  assign accept   = in_valid && in_ready;
  assign push     = accept && in_flag && (in_row <= LAST_ROW);
  assign wr_en    = (count != '0);
  assign commit   = wr_en && wr_grant;

  row_fifo #(
    .W     (ADDR_W + COLS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({in_row, in_data}),
    .pop_i   (commit),
    .head_o  (head),
    .count_o (count)
  );

  assign {wr_addr, wr_data} = head;
  assign fill               = count;

  // Frame progress FSM; frame_done is registered and lasts the single DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (commit) begin
        if (wr_addr == LAST_ROW) begin
          state_q      <= DONE;
          frame_done_q <= 1'b1;
        end else begin
          state_q <= RUN;
        end
      end else begin
        case (state_q)
          DONE:    state_q <= IDLE;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign frame_done = frame_done_q;

`ifdef LWB_SEQ_CHECK_EN
  logic [ADDR_W-1:0] exp_row_q;
  logic              seq_err_q;

  // Expected-row tracker: resyncs to in_row+1 on every pushed row, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_row_q <= '0;
      seq_err_q <= 1'b0;
    end else if (push) begin
      if (in_row != exp_row_q) seq_err_q <= 1'b1;
      exp_row_q <= (in_row == LAST_ROW) ? '0 : in_row + 1'b1;
    end else if (accept && in_flag) begin
      seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`endif
endmodule
